ms_seq_reg_link: RTL and testbench
==================================

Name: ms_seq_reg_link

Overview:
- Self-contained master/slave pair joined by a 2-bit address / 8-bit data bus with a single-wire slave-ready handshake.
- The master walks addresses 0,1,2,3 and drives data equal to 4 × its previous address.
- The slave delays the address one cycle and writes the bus data into one of four local registers.
- The slave inserts a one-cycle stall whenever the master presents address 3. The block serves as a bus/handshake demonstrator, and all internal state is exported for observation.

Parameters:
- ADDR_W, 2, address bus width; fixed at 2 (four slave registers).
- DATA_W, 8, data bus width.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst  input  1  asynchronous, active-high reset.
- addr  output  ADDR_W  master address register.
- data  output  DATA_W  master data register.
- sready  output  1  slave ready (combinational).
- reg_a  output  8  slave register 0.
- reg_b  output  8  slave register 1.
- reg_c  output  1  slave register 2.
- reg_d  output  4  slave register 3.

Behaviour:
- Reset (rst=1, asynchronous, takes effect immediately without a clock edge):
  - addr=0, data=0.
  - Internal addr_dly=0; internal dly=1.
  - reg_a=0, reg_b=0, reg_c=0, reg_d=0.
  - Consequently sready=1 throughout reset.
- Master, on each rising clk with rst=0:
  - If sready=1: addr <= addr+1, wrapping 3→0; data <= {addr,2'b00}, i.e. old addr × 4, zero-extended to DATA_W.
  - If sready=0: addr and data hold.
- Slave address pipeline: addr_dly <= addr every clock, regardless of sready.
- Slave write, every clock, selected by the old addr_dly and using the old data:
  - 0 → reg_a <= data.
  - 1 → reg_b <= data.
  - 2 → reg_c <= data[0].
  - 3 → reg_d <= data[3:0].
  - Exactly one register is written per cycle; the others hold. There is no write enable; writes occur even while stalled.
- Ready logic: sready = ~(addr==3) | ~dly, where dly <= sready every clock.
  - The first cycle with addr==3 gives sready=0, which drops dly to 0.
  - The next cycle gives sready=1 and the master advances.
  - This yields exactly one stall cycle per visit to address 3.
- Steady-state sequence: period 5 cycles. addr runs 0,1,2,3,3; data runs 12,0,4,8,8.
- Write-to-register latency: address presented at edge N selects the register written at edge N+1. The value written is the data register content at edge N+1.
- Reset released mid-sequence: everything restarts from the reset state, with the first advance on the first clock after deassertion.
- Reset asserted mid-stall: the stall is cancelled (dly=1, addr=0).

Test Plan:
- Reset check: hold rst=1 for 5 clocks → addr=0, data=0, sready=1, reg_a..reg_d=0. Assert rst between clock edges → all outputs clear without waiting for an edge.
- First pass after deassert. Post-edge states (addr,data) must be (1,0),(2,4),(3,8),(3,8),(0,12),(1,0). sready must be 0 only in the first addr=3 cycle.
- Register contents after 6 edges: reg_a=0, reg_b=4, reg_c=0, reg_d=12. reg_d must have taken 8 on edge 5 and 12 on edge 6.
- Periodicity over 20 clocks: addr=3 occupies exactly 2 consecutive cycles per 5-cycle period. sready is low exactly once per period; data never exceeds 12.
- Mid-run reset: assert rst while addr=3 and sready=0 → addr=0, sready=1 immediately. Deassert → the sequence repeats identically to the first pass.
- Width/truncation: confirm reg_c captures only data[0] and reg_d only data[3:0]. Confirm the addr 3→0 wrap produces no carry into other state.

Source files
------------

// File: rtl/ms_seq_reg_link_if.sv
// Observation bus of the sequencing master/slave pair.
// master: driven by ms_seq_reg_link; slave: read by observers.
interface ms_seq_reg_link_if #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              sready;
  logic [7:0]        reg_a;
  logic [7:0]        reg_b;
  logic              reg_c;
  logic [3:0]        reg_d;

  modport master (
    output addr, data, sready,
    output reg_a, reg_b, reg_c, reg_d
  );

  modport slave (
    input addr, data, sready,
    input reg_a, reg_b, reg_c, reg_d
  );
endinterface

// File: rtl/ms_seq_reg_link.sv
// Master walks addr 0..3 with data = 4*old addr; slave writes
// delayed-addr register, stalls one cycle on addr 3.
// Ports: clk, rst (async high), bus (master modport).
module ms_seq_reg_link #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  ms_seq_reg_link_if.master  bus
);

  localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};
  localparam int PAD = DATA_W - ADDR_W - 2;

  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [ADDR_W-1:0] r_addr_dly;
  logic              r_dly;
  logic [7:0]        r_reg_a;
  logic [7:0]        r_reg_b;
  logic              r_reg_c;
  logic [3:0]        r_reg_d;
  logic              w_sready;
  logic [DATA_W-1:0] w_next_data;

  // Low only on the first cycle at the last address.
  assign w_sready = (r_addr != LAST) | ~r_dly;
  assign w_next_data = {{PAD{1'b0}}, r_addr, 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr <= '0;
      r_data <= '0;
    end else if (w_sready) begin
      r_addr <= r_addr + 1'b1;
      r_data <= w_next_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr_dly <= '0;
      r_dly      <= 1'b1;
    end else begin
      r_addr_dly <= r_addr;
      r_dly      <= w_sready;
    end
  end

  // No write enable: a register is written every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reg_a <= '0;
      r_reg_b <= '0;
      r_reg_c <= 1'b0;
      r_reg_d <= '0;
    end else begin
      unique case (r_addr_dly)
        2'd0: r_reg_a <= r_data[7:0];
        2'd1: r_reg_b <= r_data[7:0];
        2'd2: r_reg_c <= r_data[0];
        2'd3: r_reg_d <= r_data[3:0];
        default: ;
      endcase
    end
  end

  assign bus.addr   = r_addr;
  assign bus.data   = r_data;
  assign bus.sready = w_sready;
  assign bus.reg_a  = r_reg_a;
  assign bus.reg_b  = r_reg_b;
  assign bus.reg_c  = r_reg_c;
  assign bus.reg_d  = r_reg_d;

endmodule

// File: tb/tb_ms_seq_reg_link.sv
// Randomized reset/run bench for ms_seq_reg_link against a
// table-driven model of the 5-cycle sequence.
module tb_ms_seq_reg_link;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ms_seq_reg_link_if #(.ADDR_W(2), .DATA_W(8)) u_if ();

  ms_seq_reg_link u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.master)
  );

  // Model: n = edges since reset; position in 5-cycle period.
  int unsigned m_n;
  int unsigned m_addr;
  int unsigned m_data;
  int unsigned m_addr_prev;
  int unsigned m_regs [4];
  int unsigned atab [5] = '{0, 1, 2, 3, 3};
  int unsigned dtab [5] = '{12, 0, 4, 8, 8};
  int unsigned masks [4] = '{255, 255, 1, 15};

  task automatic chk(input string tag, input int unsigned obs,
                     input int unsigned exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_n = 0;
    m_addr = 0;
    m_data = 0;
    m_addr_prev = 0;
    foreach (m_regs[i]) m_regs[i] = 0;
  endtask

  task automatic m_step();
    m_regs[m_addr_prev] = m_data & masks[m_addr_prev];
    m_addr_prev = m_addr;
    m_n++;
    m_addr = atab[m_n % 5];
    m_data = dtab[m_n % 5];
  endtask

  function automatic int unsigned m_ready();
    return (m_n % 5 == 3) ? 0 : 1;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".addr"},   u_if.addr,   m_addr);
    chk({tag, ".data"},   u_if.data,   m_data);
    chk({tag, ".sready"}, u_if.sready, m_ready());
    chk({tag, ".reg_a"},  u_if.reg_a,  m_regs[0]);
    chk({tag, ".reg_b"},  u_if.reg_b,  m_regs[1]);
    chk({tag, ".reg_c"},  u_if.reg_c,  m_regs[2]);
    chk({tag, ".reg_d"},  u_if.reg_d,  m_regs[3]);
    if (u_if.data > 8'd12)
      chk({tag, ".data_max"}, u_if.data, 12);
  endtask

  // One clock with rst low, then compare at the falling edge.
  task automatic run_cycle(input string tag);
    @(posedge clk);
    m_step();
    @(negedge clk);
    check_all(tag);
  endtask

  // Assert reset between edges and confirm it bites immediately.
  task automatic async_reset(input string tag);
    int hold;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    m_reset();
    check_all(tag);
    hold = $urandom_range(1, 3);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_all({tag, ".hold"});
    end
    rst = 1'b0;
  endtask

  initial begin
    int len;
    int waited;
    m_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_all("rst_hold");
    end
    rst = 1'b0;

    // First pass plus periodicity window.
    for (int i = 0; i < 20; i++) run_cycle("pass1");

    for (int it = 0; it < 40; it++) begin
      len = $urandom_range(0, 12);
      for (int i = 0; i < len; i++) run_cycle("run");
      if ($urandom_range(0, 1) == 1) begin
        waited = 0;
        while (m_ready() != 0 && waited < 10) begin
          run_cycle("to_stall");
          waited++;
        end
        chk("stall_reached", m_ready(), 0);
        chk("stall_sready", u_if.sready, 0);
        async_reset("rst_stall");
      end else begin
        async_reset("rst_rand");
      end
      for (int i = 0; i < 6; i++) run_cycle("after_rst");
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 0, want 1");
    $fatal(1, "timeout");
  end

endmodule
